tagged_mem_responder: RTL and testbench
=======================================

TAGGED_MEM_RESPONDER -- requirements
Module: tagged_mem_responder

Interface
REQ-001 Parameter DEPTH, default 1048576; number of 72-bit words (64 data + 8 tag) implemented.
REQ-002 Parameter LATENCY, default 2; read wait cycles, legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 i_ad  input  64  address (astb cycle, bits [19:0] = word address) or write data (wr cycle).
REQ-006 i_tag  input  8  write tag, sampled with i_wr.
REQ-007 i_astb  input  1  address strobe, one-cycle pulse.
REQ-008 i_atomic  input  1  read-modify-write flag, sampled with i_astb.
REQ-009 i_rd  input  1  read request, one-cycle pulse.
REQ-010 i_wr  input  1  write request, one-cycle pulse.
REQ-011 o_data  output  64  read data, valid while o_ready=1.
REQ-012 o_tag  output  8  read tag, valid while o_ready=1.
REQ-013 o_ready  output  1  one-cycle completion pulse for a read or write.
REQ-014 o_nomem  output  1  one-cycle pulse replacing o_ready when the address is not present.

Function
REQ-015 States: IDLE, ARMED, RWAIT, LOCKED.
REQ-016 IDLE: i_astb=1 latches addr=i_ad[19:0] and atomic=i_atomic, goes to ARMED; i_rd/i_wr ignored.
REQ-017 ARMED: i_astb=1 re-latches addr/atomic, stays ARMED; rd/wr in the same cycle are ignored.
REQ-018 ARMED, i_wr=1: store {i_tag,i_ad} at addr; o_ready=1 next cycle; go to IDLE.
REQ-019 ARMED, i_rd=1: load counter with LATENCY; go to RWAIT.
REQ-020 ARMED, i_rd=1 and i_wr=1 together: treated as write only.
REQ-021 RWAIT: counter decrements each cycle. At 0: o_data/o_tag = stored word, o_ready=1 for one cycle. Go to LOCKED if atomic, else IDLE. Read latency from i_rd to o_ready = LATENCY+1 cycles.
REQ-022 RWAIT: i_astb, i_rd, i_wr ignored.
REQ-023 LOCKED: i_wr=1 writes to the latched addr without a new astb; o_ready next cycle; go to IDLE.
REQ-024 LOCKED: i_astb and i_rd ignored. Lock is held until a write or reset.
REQ-025 addr >= DEPTH: storage is not accessed. o_nomem pulses instead of o_ready at the same cycle. o_data/o_tag = 0. Atomic lock is not entered.
REQ-026 o_data/o_tag are 0 in every cycle where o_ready=0.
REQ-027 o_ready and o_nomem are never 1 in the same cycle.
REQ-028 Write and readback of the same word: a read armed in the cycle after the write's o_ready returns the new value.

Reset
REQ-029 reset=0 at a clock edge: state=IDLE, counter=0, lock cleared, o_ready=0, o_nomem=0, o_data=0, o_tag=0.
REQ-030 Reset mid-operation aborts any pending read or lock; no completion pulse is issued.
REQ-031 Storage contents are not cleared by reset and have no defined power-up value.

Verification
REQ-032 astb ad=0x00123, wr ad=0xDEADBEEF_01234567 tag=0x35; then astb ad=0x00123, rd -> o_ready exactly 3 cycles after rd, o_data=0xDEADBEEF_01234567, o_tag=0x35.
REQ-033 astb ad=0x00010 atomic=1, rd -> o_ready with the old value; then astb ad=0x00020 (ignored) and wr ad=0x5, tag=0x1 -> o_ready 1 cycle later; read of 0x00010 returns 0x5/0x1; 0x00020 is unchanged.
REQ-034 DEPTH=1024: astb ad=0x00400, rd -> o_nomem=1 at LATENCY+1 cycles, o_ready=0, o_data=0; astb ad=0x00400, wr -> o_nomem next cycle, no store.
REQ-035 rd issued, reset=0 asserted 1 cycle later -> no o_ready/o_nomem pulse ever; state IDLE; next astb+rd completes normally.
REQ-036 LATENCY=1 and LATENCY=15 builds: rd -> o_ready at +2 and +16 cycles; i_astb/i_rd pulses during RWAIT cause no extra completion.
REQ-037 Simultaneous rd+wr in ARMED with ad=0x77 -> write performed, o_ready next cycle; readback returns 0x77.

Source files
------------

// File: rtl/tagged_mem_responder.sv
// Tagged word store answering address-strobe / read / write pulses, with programmable
// read latency, out-of-range detection and a read-modify-write lock on atomic reads.
module tagged_mem_responder #(
  parameter int unsigned DEPTH   = 1048576,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_ad,
  input  logic [7:0]  i_tag,
  input  logic        i_astb,
  input  logic        i_atomic,
  input  logic        i_rd,
  input  logic        i_wr,
  output logic [63:0] o_data,
  output logic [7:0]  o_tag,
  output logic        o_ready,
  output logic        o_nomem
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RWAIT  = 2'd2,
    LOCKED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic        atomic_q, atomic_d;
  logic        ready_q, ready_d;
  logic        nomem_q, nomem_d;
  logic        hit_q, hit_d;
  logic        mem_we, mem_re;
  logic        in_range;
  logic [AW-1:0] mem_idx;
  logic [71:0] rdata_q;
  logic [71:0] mem [DEPTH];

  assign in_range = ({12'd0, addr_q} < DEPTH);
  assign mem_idx  = AW'(addr_q);

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred; combinational logic uses blocking '='.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    atomic_d = atomic_q;
    ready_d  = 1'b0;
    nomem_d  = 1'b0;
    hit_d    = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_astb) begin
          addr_d   = i_ad[19:0];
          atomic_d = i_atomic;
          state_d  = ARMED;
        end
      end

      ARMED: begin
        // A fresh strobe wins over any rd/wr presented in the same cycle.
        if (i_astb) begin
          addr_d   = i_ad[19:0];
          atomic_d = i_atomic;
        end else if (i_wr) begin
          mem_we  = in_range;
          ready_d = in_range;
          nomem_d = !in_range;
          state_d = IDLE;
        end else if (i_rd) begin
          cnt_d   = 4'(LATENCY);
          state_d = RWAIT;
        end
      end

      RWAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          mem_re  = in_range;
          hit_d   = in_range;
          ready_d = in_range;
          nomem_d = !in_range;
          state_d = (in_range && atomic_q) ? LOCKED : IDLE;
        end
      end

      LOCKED: begin
        // The second half of the read-modify-write reuses the latched address.
        if (i_wr) begin
          mem_we  = in_range;
          ready_d = in_range;
          nomem_d = !in_range;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 20'd0;
      atomic_q <= 1'b0;
      ready_q  <= 1'b0;
      nomem_q  <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      atomic_q <= atomic_d;
      ready_q  <= ready_d;
      nomem_q  <= nomem_d;
      hit_q    <= hit_d;
    end
  end

  // NOTE: the storage array and its read register carry no reset so they map onto
  // block RAM; enables are still qualified by reset so an aborted access cannot land.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[mem_idx] <= {i_tag, i_ad};
    end
    if (reset && mem_re) begin
      rdata_q <= mem[mem_idx];
    end
  end

  // hit_q qualifies the unreset read register, keeping the outputs at zero otherwise.
  assign o_ready = ready_q;
  assign o_nomem = nomem_q;
  assign o_data  = hit_q ? rdata_q[63:0]  : 64'd0;
  assign o_tag   = hit_q ? rdata_q[71:64] : 8'd0;

  a_ready_nomem_excl : assert property (@(posedge clk) disable iff (!reset)
    !(o_ready && o_nomem));

  a_hit_implies_ready : assert property (@(posedge clk) disable iff (!reset)
    hit_q |-> ready_q);

endmodule

// File: tb/tb_tagged_mem_responder.sv
// Randomized self-checking bench: three responders (latency 2, 1, 15; 1024 words)
// compared against a transaction-level model of storage, timing and pulse counts.
module tb_tagged_mem_responder;

  localparam int NI    = 3;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [NI];
  logic [63:0] ad     [NI];
  logic [7:0]  tg     [NI];
  logic        astb   [NI];
  logic        atomic [NI];
  logic        rd     [NI];
  logic        wr     [NI];
  logic [63:0] odata  [NI];
  logic [7:0]  otag   [NI];
  logic        ordy   [NI];
  logic        onomem [NI];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  int pulses     [NI];
  int exp_pulses [NI];

  logic [71:0] mem_m [NI][DEPTH];
  bit          known [NI][DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    tagged_mem_responder #(
      .DEPTH  (DEPTH),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 15))
    ) u_dut (
      .clk     (clk),
      .reset   (rst_n[g]),
      .i_ad    (ad[g]),
      .i_tag   (tg[g]),
      .i_astb  (astb[g]),
      .i_atomic(atomic[g]),
      .i_rd    (rd[g]),
      .i_wr    (wr[g]),
      .o_data  (odata[g]),
      .o_tag   (otag[g]),
      .o_ready (ordy[g]),
      .o_nomem (onomem[g])
    );
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Output invariants and completion-pulse counting, every cycle on every instance.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < NI; g++) begin
        check("ready_nomem_excl", 64'(ordy[g] & onomem[g]), '0);
        if (!ordy[g]) begin
          check("idle_data", odata[g], '0);
          check("idle_tag", 64'(otag[g]), '0);
        end
        if (ordy[g] || onomem[g]) pulses[g]++;
      end
    end
  end

  function automatic logic [63:0] rand_ad(input logic [19:0] a);
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    v[19:0] = a;
    return v;
  endfunction

  function automatic logic [19:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 20'hFFFFF;
    if (r < 3)  return 20'(DEPTH + $urandom_range(0, 7));
    return 20'($urandom_range(0, 31));
  endfunction

  function automatic bit in_rng(input logic [19:0] a);
    return int'(a) < DEPTH;
  endfunction

  // One-cycle input pulse; sc is the cycle number of the clock edge that samples it.
  task automatic drive(input int g, input logic a, input logic at, input logic r,
                       input logic w, input logic [63:0] d, input logic [7:0] t,
                       output int sc);
    @(posedge clk); #1;
    astb[g] = a; atomic[g] = at; rd[g] = r; wr[g] = w; ad[g] = d; tg[g] = t;
    @(posedge clk); #1;
    sc = cyc;
    astb[g] = 1'b0; atomic[g] = 1'b0; rd[g] = 1'b0; wr[g] = 1'b0; ad[g] = '0; tg[g] = '0;
  endtask

  task automatic wait_resp(input int g, input int sc, input int exp_lat, input bit exp_nomem,
                           input bit chk_data, input logic [71:0] exp_word);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ordy[g] || onomem[g]) && n < 64);
    #1;
    if (!(ordy[g] || onomem[g])) begin
      check("response_seen", 64'(ordy[g] | onomem[g]), 64'd1);
      return;
    end
    check("latency", 64'(cyc - sc + 1), 64'(exp_lat));
    check("nomem", 64'(onomem[g]), 64'(exp_nomem));
    check("ready", 64'(ordy[g]), 64'(!exp_nomem));
    if (exp_nomem) begin
      check("nomem_data", odata[g], '0);
      check("nomem_tag", 64'(otag[g]), '0);
    end else if (chk_data) begin
      check("rd_data", odata[g], exp_word[63:0]);
      check("rd_tag", 64'(otag[g]), 64'(exp_word[71:64]));
    end
    exp_pulses[g]++;
    check("pulse_count", 64'(pulses[g]), 64'(exp_pulses[g]));
  endtask

  task automatic model_write(input int g, input logic [19:0] a, input logic [63:0] d,
                             input logic [7:0] t, input int sc);
    if (in_rng(a)) begin
      mem_m[g][a[9:0]] = {t, d};
      known[g][a[9:0]] = 1'b1;
      wait_resp(g, sc, 1, 1'b0, 1'b0, '0);
    end else begin
      wait_resp(g, sc, 1, 1'b1, 1'b0, '0);
    end
  endtask

  task automatic op_write(input int g, input logic [19:0] a, input logic [63:0] d,
                          input logic [7:0] t, input bit relatch, input bit both);
    int sc;
    if (relatch) drive(g, 1'b1, 1'b1, 1'b0, 1'b0, rand_ad(rand_addr()), '0, sc);
    drive(g, 1'b1, 1'b0, 1'b0, 1'b0, rand_ad(a), '0, sc);
    drive(g, 1'b0, 1'b0, both, 1'b1, d, t, sc);
    model_write(g, a, d, t, sc);
  endtask

  task automatic op_read(input int g, input logic [19:0] a, input bit at, input bit noise,
                         output bit locked);
    int sc, sc_rd;
    drive(g, 1'b1, at, 1'b0, 1'b0, rand_ad(a), '0, sc);
    drive(g, 1'b0, 1'b0, 1'b1, 1'b0, rand_ad(rand_addr()), '0, sc_rd);
    if (noise) begin
      drive(g, 1'b1, 1'b0, 1'b0, 1'b0, rand_ad(rand_addr()), '0, sc);
      drive(g, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, sc);
    end
    if (in_rng(a)) begin
      wait_resp(g, sc_rd, lat_of(g) + 1, 1'b0, known[g][a[9:0]], mem_m[g][a[9:0]]);
      locked = at;
    end else begin
      wait_resp(g, sc_rd, lat_of(g) + 1, 1'b1, 1'b0, '0);
      locked = 1'b0;
    end
  endtask

  // Write half of a locked read-modify-write; strobes and reads beforehand are ignored.
  task automatic locked_write(input int g, input logic [19:0] lock_a, input bit noise,
                              input logic [19:0] noise_a, input logic [63:0] d,
                              input logic [7:0] t);
    int sc;
    if (noise) begin
      drive(g, 1'b1, 1'b0, 1'b0, 1'b0, rand_ad(noise_a), '0, sc);
      drive(g, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, sc);
    end
    drive(g, 1'b0, 1'b0, 1'b0, 1'b1, d, t, sc);
    model_write(g, lock_a, d, t, sc);
  endtask

  task automatic pulse_reset(input int g);
    @(posedge clk); #1 rst_n[g] = 1'b0;
    @(posedge clk); #1 rst_n[g] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit lk;
    int sc;
    for (int g = 0; g < NI; g++) begin
      rst_n[g] = 1'b0; ad[g] = '0; tg[g] = '0; astb[g] = 1'b0; atomic[g] = 1'b0;
      rd[g] = 1'b0; wr[g] = 1'b0; pulses[g] = 0; exp_pulses[g] = 0;
      for (int i = 0; i < DEPTH; i++) known[g][i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    for (int g = 0; g < NI; g++) begin
      check("rst_ready", 64'(ordy[g]), '0);
      check("rst_nomem", 64'(onomem[g]), '0);
      check("rst_data", odata[g], '0);
      check("rst_tag", 64'(otag[g]), '0);
      rst_n[g] = 1'b1;
    end

    // Basic write then read of one word.
    op_write(0, 20'h00123, 64'hDEADBEEF_01234567, 8'h35, 1'b0, 1'b0);
    op_read(0, 20'h00123, 1'b0, 1'b0, lk);

    for (int i = 0; i < 32; i++)
      op_write(0, 20'(i), {$urandom(), $urandom()}, 8'($urandom()), 1'b0, 1'b0);

    // Atomic read-modify-write; the strobe to 0x20 while locked must not move the address.
    op_read(0, 20'h00010, 1'b1, 1'b0, lk);
    check("atomic_locked", 64'(lk), 64'd1);
    locked_write(0, 20'h00010, 1'b1, 20'h00020, 64'h5, 8'h1);
    op_read(0, 20'h00010, 1'b0, 1'b0, lk);
    op_read(0, 20'h00020, 1'b0, 1'b0, lk);

    // First address past the end: read and write both report no memory; word 0 untouched.
    op_read(0, 20'h00400, 1'b1, 1'b0, lk);
    op_write(0, 20'h00400, 64'hBAD0_BAD0_BAD0_BAD0, 8'hEE, 1'b0, 1'b0);
    op_read(0, 20'h00000, 1'b0, 1'b0, lk);

    // Read and write together in ARMED act as a write.
    op_write(0, 20'h00077, 64'h77, 8'h77, 1'b0, 1'b1);
    op_read(0, 20'h00077, 1'b0, 1'b0, lk);

    // Reset one cycle after a read: the read is abandoned without any pulse.
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, rand_ad(20'h00005), '0, sc);
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, sc);
    rst_n[0] = 1'b0;
    @(posedge clk); #1 rst_n[0] = 1'b1;
    repeat (20) @(negedge clk);
    #1 check("abort_pulses", 64'(pulses[0]), 64'(exp_pulses[0]));
    op_read(0, 20'h00005, 1'b0, 1'b0, lk);

    // Reset while locked releases the lock, so a new strobe is honoured again.
    op_read(0, 20'h00005, 1'b1, 1'b0, lk);
    pulse_reset(0);
    op_write(0, 20'h00006, 64'h0123_4567_89AB_CDEF, 8'h66, 1'b0, 1'b0);
    op_read(0, 20'h00006, 1'b0, 1'b0, lk);
    op_read(0, 20'h00005, 1'b0, 1'b0, lk);

    for (int it = 0; it < 150; it++) begin
      logic [19:0] a;
      logic [63:0] d;
      logic [7:0]  t;
      int kind;
      a = rand_addr();
      d = {$urandom(), $urandom()};
      t = 8'($urandom());
      kind = $urandom_range(0, 3);
      case (kind)
        0: op_write(0, a, d, t, 1'($urandom_range(0, 1)), 1'b0);
        1: op_read(0, a, 1'b0, 1'b0, lk);
        2: begin
          op_read(0, a, 1'b1, 1'b0, lk);
          if (lk) locked_write(0, a, 1'($urandom_range(0, 1)), rand_addr(), d, t);
        end
        default: op_write(0, a, d, t, 1'b0, 1'b1);
      endcase
    end

    // Latency 1 and 15 builds, including ignored strobes/reads during the wait.
    for (int g = 1; g < NI; g++) begin
      op_write(g, 20'h00003, {$urandom(), $urandom()}, 8'($urandom()), 1'b0, 1'b0);
      op_write(g, 20'h00009, {$urandom(), $urandom()}, 8'($urandom()), 1'b0, 1'b0);
      op_read(g, 20'h00003, 1'b0, lat_of(g) >= 5, lk);
      op_read(g, 20'h00009, 1'b1, lat_of(g) >= 5, lk);
      if (lk) locked_write(g, 20'h00009, 1'b1, 20'h00003, 64'hFACE, 8'h9);
      op_read(g, 20'h00009, 1'b0, 1'b0, lk);
      op_read(g, 20'h00003, 1'b0, 1'b0, lk);
      op_read(g, 20'h00401, 1'b0, 1'b0, lk);
    end

    repeat (4) @(negedge clk);
    #1;
    for (int g = 0; g < NI; g++)
      check("final_pulses", 64'(pulses[g]), 64'(exp_pulses[g]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
